// File: rtl/ex_cond_stage_if.sv
// E-stage inputs and E/M outputs of the condition/flag unit, bundled for the pipeline.
// The DUT uses the slave view; the pipeline (or a bench) uses the master view.
interface ex_cond_stage_if;
  logic [31:0] ALUResultE;
  logic [3:0]  ALUFlagsE;
  logic [3:0]  CondE;
  logic [1:0]  FlagWriteE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        MemtoRegE;
  logic        PCSrcE;
  logic [31:0] WriteDataE;
  logic [3:0]  WA3E;
  logic        StallE;
  logic        KillE;
  logic [3:0]  Flags;
  logic        CondExE;
  logic        BranchTakenE;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  WA3M;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic        PCSrcM;

  modport master (
    output ALUResultE, ALUFlagsE, CondE, FlagWriteE, RegWriteE, MemWriteE,
           MemtoRegE, PCSrcE, WriteDataE, WA3E, StallE, KillE,
    input  Flags, CondExE, BranchTakenE, ALUResultM, WriteDataM, WA3M,
           RegWriteM, MemWriteM, MemtoRegM, PCSrcM
  );

  modport slave (
    input  ALUResultE, ALUFlagsE, CondE, FlagWriteE, RegWriteE, MemWriteE,
           MemtoRegE, PCSrcE, WriteDataE, WA3E, StallE, KillE,
    output Flags, CondExE, BranchTakenE, ALUResultM, WriteDataM, WA3M,
           RegWriteM, MemWriteM, MemtoRegM, PCSrcM
  );
endinterface

// File: rtl/ex_cond_stage.sv
// Execute-stage condition unit: owns NZCV, evaluates CondE against it, gates side
// effects and registers the surviving instruction into the E/M pipeline register.
module ex_cond_stage (
  input logic            clk,
  input logic            reset,
  ex_cond_stage_if.slave bus
);
  logic [3:0]  flagReg;
  logic        condPass;
  logic        condExE;
  logic        flagWriteOk;
  logic [31:0] aluResultM;
  logic [31:0] writeDataM;
  logic [3:0]  wa3M;
  logic        regWriteM;
  logic        memWriteM;
  logic        memtoRegM;
  logic        pcSrcM;

  // Decode uses the committed flags, never this instruction's own ALU flags.
  always_comb begin
    condPass = 1'b0;
    case (bus.CondE)
      4'b0000: condPass = flagReg[2];
      4'b0001: condPass = ~flagReg[2];
      4'b0010: condPass = flagReg[1];
      4'b0011: condPass = ~flagReg[1];
      4'b0100: condPass = flagReg[3];
      4'b0101: condPass = ~flagReg[3];
      4'b0110: condPass = flagReg[0];
      4'b0111: condPass = ~flagReg[0];
      4'b1000: condPass = flagReg[1] & ~flagReg[2];
      4'b1001: condPass = ~flagReg[1] | flagReg[2];
      4'b1010: condPass = (flagReg[3] == flagReg[0]);
      4'b1011: condPass = (flagReg[3] != flagReg[0]);
      4'b1100: condPass = ~flagReg[2] & (flagReg[3] == flagReg[0]);
      4'b1101: condPass = flagReg[2] | (flagReg[3] != flagReg[0]);
      4'b1110: condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

  assign condExE     = condPass & ~bus.KillE;
  assign flagWriteOk = condExE & ~bus.StallE;

  // NZ and CV halves commit independently so partial flag setters keep the other pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flagReg <= 4'b0000;
    end else if (flagWriteOk) begin
      if (bus.FlagWriteE[1]) flagReg[3:2] <= bus.ALUFlagsE[3:2];
      if (bus.FlagWriteE[0]) flagReg[1:0] <= bus.ALUFlagsE[1:0];
    end
  end

  // Kill beats stall; a failed condition still carries its data but no side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aluResultM <= '0;
      writeDataM <= '0;
      wa3M       <= '0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      memtoRegM  <= 1'b0;
      pcSrcM     <= 1'b0;
    end else if (bus.KillE) begin
      aluResultM <= '0;
      writeDataM <= '0;
      wa3M       <= '0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      memtoRegM  <= 1'b0;
      pcSrcM     <= 1'b0;
    end else if (!bus.StallE) begin
      aluResultM <= bus.ALUResultE;
      writeDataM <= bus.WriteDataE;
      wa3M       <= bus.WA3E;
      regWriteM  <= bus.RegWriteE & condExE;
      memWriteM  <= bus.MemWriteE & condExE;
      memtoRegM  <= bus.MemtoRegE & condExE;
      pcSrcM     <= bus.PCSrcE & condExE;
    end
  end

  assign bus.Flags        = flagReg;
  assign bus.CondExE      = condExE;
  assign bus.BranchTakenE = condExE & bus.PCSrcE;
  assign bus.ALUResultM   = aluResultM;
  assign bus.WriteDataM   = writeDataM;
  assign bus.WA3M         = wa3M;
  assign bus.RegWriteM    = regWriteM;
  assign bus.MemWriteM    = memWriteM;
  assign bus.MemtoRegM    = memtoRegM;
  assign bus.PCSrcM       = pcSrcM;
endmodule

// File: tb/tb_ex_cond_stage.sv
// Bench for ex_cond_stage: directed literal checks plus randomized traffic compared
// every cycle against an architectural model of the flags and the E/M register.
module tb_ex_cond_stage;
  logic clk;
  logic reset;
  ex_cond_stage_if bus ();

  ex_cond_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0]  mFlags = '0;
  logic [31:0] mAluM  = '0;
  logic [31:0] mWdM   = '0;
  logic [3:0]  mWa3M  = '0;
  logic [3:0]  mCtlM  = '0;
  logic        mPass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conditions come in complementary pairs; the low bit of the code inverts the pair's base test.
  function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) return 1'b0;
    return base ^ cond[0];
  endfunction

  assign mPass = condHolds(bus.CondE, mFlags) && !bus.KillE;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mFlags <= '0;
      mAluM  <= '0;
      mWdM   <= '0;
      mWa3M  <= '0;
      mCtlM  <= '0;
    end else begin
      if (mPass && !bus.StallE) begin
        mFlags <= {bus.FlagWriteE[1] ? bus.ALUFlagsE[3:2] : mFlags[3:2],
                   bus.FlagWriteE[0] ? bus.ALUFlagsE[1:0] : mFlags[1:0]};
      end
      if (bus.KillE) begin
        mAluM <= '0;
        mWdM  <= '0;
        mWa3M <= '0;
        mCtlM <= '0;
      end else if (!bus.StallE) begin
        mAluM <= bus.ALUResultE;
        mWdM  <= bus.WriteDataE;
        mWa3M <= bus.WA3E;
        mCtlM <= mPass ? {bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE, bus.PCSrcE} : 4'b0000;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] ctlM();
    return {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM};
  endfunction

  // Every cycle, away from the rising edge, the DUT must agree with the model.
  always @(negedge clk) begin
    checkOutput("cmpFlags", bus.Flags, mFlags);
    checkOutput("cmpCondExE", bus.CondExE, condHolds(bus.CondE, mFlags) & ~bus.KillE);
    checkOutput("cmpBranchTakenE", bus.BranchTakenE,
                condHolds(bus.CondE, mFlags) & ~bus.KillE & bus.PCSrcE);
    checkOutput("cmpALUResultM", bus.ALUResultM, mAluM);
    checkOutput("cmpWriteDataM", bus.WriteDataM, mWdM);
    checkOutput("cmpWA3M", bus.WA3M, mWa3M);
    checkOutput("cmpCtlM", ctlM(), mCtlM);
  end

  task automatic applyStimulus(input logic [31:0] alu, input logic [3:0] aluFlags,
                               input logic [3:0] cond, input logic [1:0] fw,
                               input logic [3:0] ctl, input logic [31:0] wd,
                               input logic [3:0] wa, input logic stall, input logic kill);
    bus.ALUResultE = alu;
    bus.ALUFlagsE  = aluFlags;
    bus.CondE      = cond;
    bus.FlagWriteE = fw;
    {bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE, bus.PCSrcE} = ctl;
    bus.WriteDataE = wd;
    bus.WA3E       = wa;
    bus.StallE     = stall;
    bus.KillE      = kill;
  endtask

  task automatic randomStimulus();
    applyStimulus($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(32'h0, 4'h0, 4'h0, 2'b00, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetFlags", bus.Flags, 32'h0);
    checkOutput("resetALUResultM", bus.ALUResultM, 32'h0);
    checkOutput("resetCtlM", ctlM(), 32'h0);
    reset = 1'b1;

    // Flag path: AL setter, then EQ passes, NE fails but data still loads.
    applyStimulus(32'h1111, 4'b0100, 4'b1110, 2'b11, 4'b1000, 32'h0, 4'h1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("flagPathFlags", bus.Flags, 32'h4);
    applyStimulus(32'h2222, 4'b0000, 4'b0000, 2'b00, 4'b1000, 32'h0, 4'h2, 1'b0, 1'b0);
    #1 checkOutput("eqCondExE", bus.CondExE, 32'h1);
    nextCycle();
    checkOutput("eqRegWriteM", bus.RegWriteM, 32'h1);
    applyStimulus(32'hABCD, 4'b0000, 4'b0001, 2'b00, 4'b1000, 32'h0, 4'h3, 1'b0, 1'b0);
    #1 checkOutput("neCondExE", bus.CondExE, 32'h0);
    nextCycle();
    checkOutput("neRegWriteM", bus.RegWriteM, 32'h0);
    checkOutput("neALUResultM", bus.ALUResultM, 32'hABCD);

    // Partial update touches only N and Z.
    applyStimulus(32'h0, 4'b1111, 4'b1110, 2'b11, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("allSetFlags", bus.Flags, 32'hF);
    applyStimulus(32'h0, 4'b0000, 4'b1110, 2'b10, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("partialFlags", bus.Flags, 32'h3);

    // Full condition sweep over every flag value and code.
    for (int f = 0; f < 16; f++) begin
      applyStimulus(32'(f), 4'(f), 4'b1110, 2'b11, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("sweepFlags", bus.Flags, 32'(f));
      for (int c = 0; c < 16; c++) begin
        applyStimulus($urandom, 4'($urandom_range(0, 15)), 4'(c), 2'b00, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1 checkOutput("condSweep", bus.CondExE, condHolds(4'(c), 4'(f)));
        nextCycle();
      end
    end

    // Hand-computed pins with Z=1, C=1: HI fails, LS and LE pass, never-code fails.
    applyStimulus(32'h0, 4'b0110, 4'b1110, 2'b11, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    nextCycle();
    bus.CondE = 4'b1000;
    #1 checkOutput("pinHI", bus.CondExE, 32'h0);
    bus.CondE = 4'b1001;
    #1 checkOutput("pinLS", bus.CondExE, 32'h1);
    bus.CondE = 4'b1101;
    #1 checkOutput("pinLE", bus.CondExE, 32'h1);
    bus.CondE = 4'b1111;
    #1 checkOutput("pinNV", bus.CondExE, 32'h0);
    nextCycle();

    // Stall with a flag setter: M and flags frozen, then exactly one commit on release.
    applyStimulus(32'h2222, 4'b0000, 4'b1110, 2'b11, 4'b1000, 32'h77, 4'h3, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(32'h5555, 4'b1010, 4'b1110, 2'b11, 4'b1100, 32'h88, 4'h4, 1'b1, 1'b0);
    repeat (3) begin
      nextCycle();
      checkOutput("stallFlags", bus.Flags, 32'h0);
      checkOutput("stallALUResultM", bus.ALUResultM, 32'h2222);
      checkOutput("stallMemWriteM", bus.MemWriteM, 32'h0);
    end
    bus.StallE = 1'b0;
    nextCycle();
    checkOutput("releaseFlags", bus.Flags, 32'hA);
    checkOutput("releaseALUResultM", bus.ALUResultM, 32'h5555);
    checkOutput("releaseMemWriteM", bus.MemWriteM, 32'h1);

    // Kill overrides stall: bubble loaded, no flag write.
    applyStimulus(32'h9999, 4'b0101, 4'b1110, 2'b11, 4'b1111, 32'h99, 4'h9, 1'b1, 1'b1);
    #1 checkOutput("killCondExE", bus.CondExE, 32'h0);
    nextCycle();
    checkOutput("killCtlM", ctlM(), 32'h0);
    checkOutput("killALUResultM", bus.ALUResultM, 32'h0);
    checkOutput("killFlags", bus.Flags, 32'hA);

    // Branch on LT with N=1, V=0, then the same branch killed.
    applyStimulus(32'h0, 4'b1000, 4'b1110, 2'b11, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(32'h10, 4'b0000, 4'b1011, 2'b00, 4'b0001, 32'h0, 4'hF, 1'b0, 1'b0);
    #1 checkOutput("branchTaken", bus.BranchTakenE, 32'h1);
    nextCycle();
    checkOutput("branchPCSrcM", bus.PCSrcM, 32'h1);
    bus.KillE = 1'b1;
    #1 checkOutput("branchKilled", bus.BranchTakenE, 32'h0);
    nextCycle();
    checkOutput("branchKilledPCSrcM", bus.PCSrcM, 32'h0);

    repeat (400) begin
      randomStimulus();
      nextCycle();
    end

    // Asynchronous reset mid-cycle, mid-stall, from a loaded state.
    applyStimulus(32'hDEAD_BEEF, 4'b1111, 4'b1110, 2'b11, 4'b1111, 32'h1234, 4'h7, 1'b0, 1'b0);
    nextCycle();
    randomStimulus();
    bus.StallE = 1'b1;
    bus.KillE  = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncResetFlags", bus.Flags, 32'h0);
    checkOutput("asyncResetALUResultM", bus.ALUResultM, 32'h0);
    checkOutput("asyncResetCtlM", ctlM(), 32'h0);
    repeat (2) begin
      randomStimulus();
      nextCycle();
    end
    reset = 1'b1;

    repeat (300) begin
      randomStimulus();
      nextCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
